// File: rtl/switch_cfg_tx.sv
// rtl/switch_cfg_tx.sv - credit-gated switch route-entry config flit transmitter with request FIFO
// Optional broadcast expansion of dest 5'h1F is enabled by defining SWITCH_CFG_TX_BCAST_EN.
module switch_cfg_tx #(
    parameter int NODE        = 1,
    parameter int FIFO_DEPTH  = 4,
    parameter int CREDITS     = 4,
    parameter int TOTAL_NODES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [4:0]  cfg_dest,
    input  logic [7:0]  cfg_addr,
    input  logic [14:0] cfg_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_id,
    output logic [4:0]  out_req,
    output logic [31:0] out_payload,
    input  logic        credit_return,
    output logic        busy
);
    localparam int          AW             = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT     = (AW+1)'(FIFO_DEPTH);
    localparam logic [3:0]  CRED_MAX       = 4'(CREDITS);
    localparam logic [4:0]  LAST_NODE      = 5'(TOTAL_NODES - 1);
    localparam logic [3:0]  FMT_SWITCH_CFG = 4'h5;
`ifdef SWITCH_CFG_TX_BCAST_EN
    localparam bit BCAST_EN = 1'b1;
`else
    localparam bit BCAST_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

    state_t            state_q, state_d;
    logic [27:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q;
    logic [3:0]        credits_q;
    logic [3:0]        id_q;
    logic [31:0]       payload_q;
    logic [4:0]        bidx_q;
    logic              push, pop, load, flit_accept, pending, is_bcast, last;
    logic [4:0]        head_dest, flit_dest;
    logic [7:0]        head_addr;
    logic [14:0]       head_data;

    assign cfg_ready   = (count_q != FULL_COUNT);
    assign push        = cfg_valid && cfg_ready;
    assign pending     = (count_q != '0) || push;
    assign {head_dest, head_addr, head_data} = mem_q[rd_ptr_q];

    // A broadcast entry stays at the FIFO head until its last expanded flit is loaded.
    assign is_bcast  = BCAST_EN && (head_dest == 5'h1F);
    assign flit_dest = is_bcast ? bidx_q : head_dest;
    assign last      = !is_bcast || (bidx_q == LAST_NODE);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (pending) state_d = LOAD;
            LOAD: if (credits_q != '0) state_d = SEND;
            SEND: if (out_ready) state_d = pending ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid   = (state_q == SEND);
        load        = (state_q == LOAD) && (credits_q != '0);
        pop         = load && last;
        flit_accept = out_valid && out_ready;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {cfg_dest, cfg_addr, cfg_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credits_q <= CRED_MAX;
        end else if (load && !credit_return) begin
            credits_q <= credits_q - 1'b1;
        end else if (!load && credit_return && credits_q < CRED_MAX) begin
            credits_q <= credits_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            payload_q <= '0;
            bidx_q    <= '0;
            id_q      <= '0;
        end else begin
            if (load) begin
                payload_q <= {FMT_SWITCH_CFG, flit_dest, head_data[14:7], head_addr, head_data[6:0]};
                bidx_q    <= last ? 5'd0 : bidx_q + 5'd1;
            end
            if (flit_accept) id_q <= id_q + 4'd1;
        end
    end

    assign out_id      = id_q;
    assign out_req     = 5'(NODE);
    assign out_payload = payload_q;
    assign busy        = (count_q != '0) || out_valid;
endmodule

// File: tb/tb_switch_cfg_tx.sv
// tb/tb_switch_cfg_tx.sv - directed self-checking bench for switch_cfg_tx
module tb_switch_cfg_tx;
    localparam logic [3:0] FMT = 4'h5;

    logic        clk = 1'b0;
    logic        rst, cfg_valid, cfg_ready, out_valid, out_ready, credit_return, busy;
    logic [4:0]  cfg_dest, out_req;
    logic [7:0]  cfg_addr;
    logic [14:0] cfg_data;
    logic [3:0]  out_id, exp_id;
    logic [31:0] out_payload;
    int          vectors = 0;
    int          miscompares = 0;
    int          seen;

    switch_cfg_tx dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_dest(cfg_dest), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_req(out_req),
        .out_payload(out_payload), .credit_return(credit_return), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pay(input logic [4:0] d, input logic [7:0] a, input logic [14:0] dt);
        return {FMT, d, dt[14:7], a, dt[6:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [4:0] d, input logic [7:0] a, input logic [14:0] dt);
        cfg_valid = 1'b1; cfg_dest = d; cfg_addr = a; cfg_data = dt;
        for (int i = 0; i < 50 && !cfg_ready; i++) @(negedge clk);
        if (!cfg_ready) chk("push_timeout", {31'd0, cfg_ready}, 32'd1);
        @(posedge clk); @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic get_flit(input logic [31:0] exp_pay, input string tag);
        for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_payload"}, out_payload, exp_pay);
        chk({tag, "_id"}, {28'd0, out_id}, {28'd0, exp_id});
        @(posedge clk); @(negedge clk);
        exp_id = exp_id + 4'd1;
    endtask

    task automatic credit_pulse();
        credit_return = 1'b1;
        @(posedge clk); @(negedge clk);
        credit_return = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_dest = '0; cfg_addr = '0; cfg_data = '0;
        out_ready = 1'b0; credit_return = 1'b0; exp_id = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        chk("rst_payload", out_payload, 32'd0);
        chk("rst_out_id", {28'd0, out_id}, 32'd0);
        chk("out_req", {27'd0, out_req}, 32'd1);
        rst = 1'b0;

        // single request, latency N+2
        out_ready = 1'b1;
        push(5'd3, 8'h12, 15'h1234);
        chk("lat_n1_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_n2_valid", {31'd0, out_valid}, 32'd1);
        chk("single_payload", out_payload, 32'h5192_0934);
        chk("single_id", {28'd0, out_id}, 32'd0);
        @(posedge clk); @(negedge clk);
        exp_id = 4'd1;
        chk("single_done_valid", {31'd0, out_valid}, 32'd0);
        chk("single_done_busy", {31'd0, busy}, 32'd0);
        credit_pulse();

        // fill FIFO with downstream stalled
        out_ready = 1'b0;
        push(5'd1, 8'h01, 15'h0101);
        push(5'd2, 8'h02, 15'h7F02);
        push(5'd4, 8'h03, 15'h4003);
        push(5'd5, 8'h04, 15'h0004);
        push(5'd6, 8'h05, 15'h5555);
        chk("full_cfg_ready", {31'd0, cfg_ready}, 32'd0);
        repeat (3) @(negedge clk);
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_payload", out_payload, pay(5'd1, 8'h01, 15'h0101));
        chk("hold_id", {28'd0, out_id}, 32'd1);
        chk("hold_cfg_ready", {31'd0, cfg_ready}, 32'd0);

        // drain: credits run out after four flits, fifth waits for a credit return
        out_ready = 1'b1;
        get_flit(pay(5'd1, 8'h01, 15'h0101), "q1");
        get_flit(pay(5'd2, 8'h02, 15'h7F02), "q2");
        get_flit(pay(5'd4, 8'h03, 15'h4003), "q3");
        get_flit(pay(5'd5, 8'h04, 15'h0004), "q4");
        repeat (5) @(negedge clk);
        chk("stall_valid", {31'd0, out_valid}, 32'd0);
        chk("stall_busy", {31'd0, busy}, 32'd1);
        credit_pulse();
        get_flit(pay(5'd6, 8'h05, 15'h5555), "q5");
        repeat (4) credit_pulse();

        // dest 5'h1F
        push(5'h1F, 8'h5A, 15'h2B3C);
`ifdef SWITCH_CFG_TX_BCAST_EN
        for (int n = 0; n < 4; n++) get_flit(pay(5'(n), 8'h5A, 15'h2B3C), "bcast");
        repeat (4) credit_pulse();
`else
        get_flit(pay(5'h1F, 8'h5A, 15'h2B3C), "bcast_off");
        credit_pulse();
`endif
        @(negedge clk);
        chk("bcast_busy", {31'd0, busy}, 32'd0);

        // id wraps modulo 16
        for (int k = 0; k < 12; k++) begin
            push(5'(k), 8'(k + 8'h40), 15'(k * 15'h0123));
            get_flit(pay(5'(k), 8'(k + 8'h40), 15'(k * 15'h0123)), "wrap");
            credit_pulse();
        end

        // reset mid-SEND with two requests queued
        out_ready = 1'b0;
        push(5'd7, 8'hA1, 15'h1111);
        push(5'd8, 8'hA2, 15'h2222);
        push(5'd9, 8'hA3, 15'h3333);
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        chk("mid_rst_payload", out_payload, 32'd0);
        chk("mid_rst_id", {28'd0, out_id}, 32'd0);
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("post_rst_flits", 32'(seen), 32'd0);

        // credits restored to four after reset
        exp_id = '0;
        for (int k = 0; k < 4; k++) begin
            push(5'(k + 10), 8'hC0, 15'(k));
            get_flit(pay(5'(k + 10), 8'hC0, 15'(k)), "cred");
        end
        push(5'd20, 8'hC4, 15'h0044);
        repeat (6) @(negedge clk);
        chk("cred_exhaust_valid", {31'd0, out_valid}, 32'd0);
        credit_pulse();
        get_flit(pay(5'd20, 8'hC4, 15'h0044), "cred_last");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
